// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full_adder cell, operand shift registers and a
// registered carry produce a WIDTH-bit sum over WIDTH clock cycles, LSB first.

// Single-bit full adder cell shared by the serial datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

module bit_serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] shift_a;
   logic [WIDTH-1:0] shift_b;
   logic             carry;
   logic [CW-1:0]    count;
   logic             fa_sum;
   logic             fa_cout;
   logic             load;
   logic             last_bit;

   // A new addition is accepted from IDLE, or straight from DONE for back-to-back use.
   assign load     = start && ((state == IDLE) || (state == DONE));
   assign last_bit = (state == RUN) && (count == LAST_BIT);

   full_adder u_full_adder (
      .a    (shift_a[0]),
      .b    (shift_b[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // State register; reset aborts any addition in progress immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: RUN for WIDTH cycles, then a single DONE cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (load) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (load) begin
               next_state = RUN;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Serial datapath: load operands on accept, then consume one bit pair per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_a <= '0;
         shift_b <= '0;
         carry   <= 1'b0;
         count   <= '0;
         sum     <= '0;
         cout    <= 1'b0;
      end else if (load) begin
         shift_a <= a;
         shift_b <= b;
         carry   <= cin;
         count   <= '0;
         sum     <= '0;
      end else if (state == RUN) begin
         shift_a <= {1'b0, shift_a[WIDTH-1:1]};
         shift_b <= {1'b0, shift_b[WIDTH-1:1]};
         carry   <= fa_cout;
         count   <= count + CW'(1);
         sum     <= {fa_sum, sum[WIDTH-1:1]};
         if (last_bit) begin
            cout <= fa_cout;
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: a transaction-level model predicts
// busy/done/sum/cout every cycle, and directed cases pin results by literal values.

module tb_bit_serial_adder;

   localparam int WIDTH = 8;
   localparam int MAX_WAIT = 40;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int checks = 0;
   int errors = 0;
   bit compare_on = 1'b0;
   int done_seen = 0;

   // Model state: cycles remaining in the current addition and the predicted result.
   int               m_remaining = 0;
   bit               m_done = 1'b0;
   bit               m_valid = 1'b1;
   logic [WIDTH-1:0] m_sum = '0;
   logic             m_cout = 1'b0;
   logic [WIDTH:0]   m_pending = '0;

   bit_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Transaction model: an accepted start yields {cout,sum} = a+b+cin after WIDTH edges.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_remaining = 0;
            m_done      = 1'b0;
            m_valid     = 1'b1;
            m_sum       = '0;
            m_cout      = 1'b0;
         end else begin
            m_done = 1'b0;
            if (m_remaining > 0) begin
               m_remaining = m_remaining - 1;
               if (m_remaining == 0) begin
                  m_done  = 1'b1;
                  m_sum   = m_pending[WIDTH-1:0];
                  m_cout  = m_pending[WIDTH];
                  m_valid = 1'b1;
               end
            end else if (start) begin
               m_pending   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
               m_remaining = WIDTH;
               m_valid     = 1'b0;
            end
         end
      end
   end

   // Cycle-by-cycle comparison of the DUT against the model, away from the active edge.
   always @(negedge clk) begin
      if (compare_on) begin
         if (done === 1'b1) done_seen++;
         checks++;
         if (busy !== (m_remaining > 0)) begin
            errors++;
            $display("[TB] FAIL model_busy: got %b expected %b at %0t", busy, (m_remaining > 0), $time);
         end
         checks++;
         if (done !== m_done) begin
            errors++;
            $display("[TB] FAIL model_done: got %b expected %b at %0t", done, m_done, $time);
         end
         checks++;
         if (busy === 1'b1 && done === 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_done_exclusive: got busy=%b done=%b expected not both at %0t", busy, done, $time);
         end
         if (m_valid) begin
            checks++;
            if (sum !== m_sum || cout !== m_cout) begin
               errors++;
               $display("[TB] FAIL model_result: got sum=%h cout=%b expected sum=%h cout=%b at %0t",
                        sum, cout, m_sum, m_cout, $time);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
      @(negedge clk);
      a     = av;
      b     = bv;
      cin   = cv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic waitDone(input string name, output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < MAX_WAIT) begin
         @(negedge clk);
         cycles++;
      end
      if (done !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s_timeout: got no done expected done within %0d cycles", name, MAX_WAIT);
      end
   endtask

   typedef struct {
      logic [WIDTH-1:0] av;
      logic [WIDTH-1:0] bv;
      logic             cv;
      logic [WIDTH-1:0] es;
      logic             ec;
   } vec_t;

   vec_t vecs[3];
   int   cyc;
   int   dones_before;

   initial begin
      vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (2) @(negedge clk);
      compare_on = 1'b1;
      rst_n = 1'b1;

      // Idle after reset
      repeat (5) @(negedge clk);
      checkOutput("idle_busy", {31'b0, busy}, 32'd0);
      checkOutput("idle_done", {31'b0, done}, 32'd0);
      checkOutput("idle_sum", {24'b0, sum}, 32'h00);
      checkOutput("idle_cout", {31'b0, cout}, 32'd0);

      // Basic add with latency check
      applyStimulus(8'h5A, 8'h3C, 1'b0);
      checkOutput("basic_busy", {31'b0, busy}, 32'd1);
      waitDone("basic", cyc);
      checkOutput("basic_latency", cyc, 32'd8);
      checkOutput("basic_sum", {24'b0, sum}, 32'h96);
      checkOutput("basic_cout", {31'b0, cout}, 32'd0);
      @(negedge clk);
      checkOutput("basic_done_pulse", {31'b0, done}, 32'd0);
      checkOutput("basic_sum_held", {24'b0, sum}, 32'h96);

      // Carry propagation vectors
      for (int i = 0; i < 3; i++) begin
         applyStimulus(vecs[i].av, vecs[i].bv, vecs[i].cv);
         waitDone("carry", cyc);
         checkOutput($sformatf("carry%0d_sum", i), {24'b0, sum}, {24'b0, vecs[i].es});
         checkOutput($sformatf("carry%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].ec});
         repeat (2) @(negedge clk);
      end

      // Start ignored while busy; operand changes after accept have no effect
      dones_before = done_seen;
      applyStimulus(8'h12, 8'h34, 1'b0);
      @(negedge clk);
      @(negedge clk);
      a = 8'hAA; b = 8'hAA; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = a + 8'h11;
         b = b - 8'h07;
         @(negedge clk);
      end
      waitDone("ignore", cyc);
      checkOutput("ignore_sum", {24'b0, sum}, 32'h46);
      checkOutput("ignore_cout", {31'b0, cout}, 32'd0);
      repeat (12) @(negedge clk);
      checkOutput("ignore_single_done", done_seen - dones_before, 32'd1);

      // Back-to-back: start asserted during the done cycle
      applyStimulus(8'h80, 8'h80, 1'b0);
      waitDone("b2b_first", cyc);
      checkOutput("b2b_first_sum", {24'b0, sum}, 32'h00);
      checkOutput("b2b_first_cout", {31'b0, cout}, 32'd1);
      a = 8'h01; b = 8'h02; cin = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("b2b_busy", {31'b0, busy}, 32'd1);
      waitDone("b2b_second", cyc);
      checkOutput("b2b_second_latency", cyc + 1, 32'd9);
      checkOutput("b2b_second_sum", {24'b0, sum}, 32'h04);
      checkOutput("b2b_second_cout", {31'b0, cout}, 32'd0);
      repeat (2) @(negedge clk);

      // Asynchronous reset mid-operation
      cin = 1'b0;
      dones_before = done_seen;
      applyStimulus(8'hF0, 8'h0F, 1'b0);
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("areset_busy", {31'b0, busy}, 32'd0);
      checkOutput("areset_done", {31'b0, done}, 32'd0);
      checkOutput("areset_sum", {24'b0, sum}, 32'h00);
      checkOutput("areset_cout", {31'b0, cout}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("areset_no_done", done_seen - dones_before, 32'd0);
      applyStimulus(8'h01, 8'h01, 1'b0);
      waitDone("post_reset", cyc);
      checkOutput("post_reset_sum", {24'b0, sum}, 32'h02);
      checkOutput("post_reset_cout", {31'b0, cout}, 32'd0);
      repeat (3) @(negedge clk);

      compare_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
